// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: opcode map, field widths, loader FSM states
// and loader error causes. The decoder and the loader both import this.
package picomips_pkg;

  localparam int OPW  = 6;
  localparam int RW   = 5;
  localparam int IMMW = 8;

  localparam logic [OPW-1:0] OP_NOP      = 6'h00;
  localparam logic [OPW-1:0] OP_ADD      = 6'h01;
  localparam logic [OPW-1:0] OP_ADDI     = 6'h02;
  localparam logic [OPW-1:0] OP_SUB      = 6'h03;
  localparam logic [OPW-1:0] OP_SUBI     = 6'h04;
  localparam logic [OPW-1:0] OP_MULL_INT = 6'h05;
  localparam logic [OPW-1:0] OP_MULL_FLT = 6'h06;
  localparam logic [OPW-1:0] OP_LDI      = 6'h07;
  localparam logic [OPW-1:0] OP_STR      = 6'h08;
  localparam logic [OPW-1:0] OP_J        = 6'h09;
  localparam logic [OPW-1:0] OP_BEQ      = 6'h0A;
  localparam logic [OPW-1:0] OP_BNE      = 6'h0B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    E_NONE     = 2'd0,
    E_OPCODE   = 2'd1,
    E_OVERFLOW = 2'd2,
    E_JUMP     = 2'd3
  } err_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational opcode legality check, per-class field masking and packing
// into a {op, rd, rs, imm} program-memory word.
module instr_encoder
  import picomips_pkg::*;
#(
  parameter int Psize = 6
) (
  input  logic [OPW-1:0]            op,
  input  logic [RW-1:0]             rd,
  input  logic [RW-1:0]             rs,
  input  logic [IMMW-1:0]           imm,
  output logic [OPW+2*RW+IMMW-1:0]  word,
  output logic                      bad,
  output err_t                      cause
);

  // Decide legality and build the masked word for the presented opcode
  always_comb begin
    word  = '0;
    bad   = 1'b0;
    cause = E_NONE;
    case (op)
      OP_NOP: word = '0;
      OP_ADD, OP_SUB, OP_MULL_INT, OP_MULL_FLT:
        word = {op, rd, rs, {IMMW{1'b0}}};
      OP_ADDI, OP_SUBI, OP_LDI:
        word = {op, rd, rs, imm};
      OP_STR:
        word = {op, {RW{1'b0}}, rs, imm};
      OP_J: begin
        // Absolute target must fit inside program memory
        if (32'(imm) >= (32'd1 << Psize)) begin
          bad   = 1'b1;
          cause = E_JUMP;
        end else begin
          word = {op, {RW{1'b0}}, {RW{1'b0}}, imm};
        end
      end
      OP_BEQ, OP_BNE:
        word = {op, {RW{1'b0}}, {RW{1'b0}}, imm};
      default: begin
        bad   = 1'b1;
        cause = E_OPCODE;
      end
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts instruction tuples on a valid/ready stream, writes
// encoded words to consecutive program-memory addresses and holds the CPU in
// reset until a complete error-free program is in place.
module prog_loader
  import picomips_pkg::*;
#(
  parameter int Psize = 6,
  parameter int Isize = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic              pm_we,
  output logic [Psize-1:0]  pm_addr,
  output logic [Isize-1:0]  pm_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [Psize:0]    count
);

  localparam logic [Psize:0] MAX_WORDS = {1'b1, {Psize{1'b0}}};

  state_t            state;
  err_t              err_q;
  logic [Psize-1:0]  addr;
  logic [Isize-1:0]  enc_word;
  logic              enc_bad;
  err_t              enc_cause;
  logic              accept;

  instr_encoder #(
    .Psize (Psize)
  ) u_enc (
    .op    (in_op),
    .rd    (in_rd),
    .rs    (in_rs),
    .imm   (in_imm),
    .word  (enc_word),
    .bad   (enc_bad),
    .cause (enc_cause)
  );

  assign accept   = (state == S_LOAD) && in_valid && in_ready;
  assign err_code = err_q;

  // Session FSM, address/count registers and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      err_q    <= E_NONE;
      count    <= '0;
      addr     <= '0;
    end else begin
      pm_we <= 1'b0;
      if (start) begin
        // start outranks a tuple accepted in the same cycle
        state    <= S_LOAD;
        in_ready <= 1'b1;
        addr     <= '0;
        count    <= '0;
        err      <= 1'b0;
        err_q    <= E_NONE;
        done     <= 1'b0;
        cpu_hold <= 1'b1;
      end else if (accept) begin
        if (enc_bad || (count == MAX_WORDS)) begin
          state    <= S_ERR;
          in_ready <= 1'b0;
          err      <= 1'b1;
          err_q    <= enc_bad ? enc_cause : E_OVERFLOW;
        end else begin
          pm_we    <= 1'b1;
          pm_addr  <= addr;
          pm_wdata <= enc_word;
          addr     <= addr + 1'b1;
          count    <= count + 1'b1;
          if (in_last) begin
            state    <= S_DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios with literal
// expectations plus a randomized stream checked every cycle against a
// session-level behavioural model.
module tb_prog_loader;
  import picomips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs;
  logic [7:0]  in_imm;
  logic        in_ready, pm_we, cpu_hold, done, err;
  logic [5:0]  pm_addr;
  logic [23:0] pm_wdata;
  logic [1:0]  err_code;
  logic [6:0]  count;

  prog_loader #(.Psize(6), .Isize(24)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs),
    .in_imm(in_imm), .in_last(in_last), .pm_we(pm_we), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
    .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rules: {error code, packed word} for a tuple
  function automatic logic [25:0] ref_enc(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [7:0] imm);
    case (op)
      OP_NOP:                                     return 26'd0;
      OP_ADD, OP_SUB, OP_MULL_INT, OP_MULL_FLT:   return {2'd0, op, rd, rs, 8'd0};
      OP_ADDI, OP_SUBI, OP_LDI:                   return {2'd0, op, rd, rs, imm};
      OP_STR:                                     return {2'd0, op, 5'd0, rs, imm};
      OP_J:   return (imm >= 8'd64) ? {2'd3, 24'd0} : {2'd0, op, 10'd0, imm};
      OP_BEQ, OP_BNE:                             return {2'd0, op, 10'd0, imm};
      default:                                    return {2'd1, 24'd0};
    endcase
  endfunction

  // Behavioural model: a session is either loading or not; track outputs
  logic        m_loading, m_we, m_hold, m_done, m_err;
  logic [1:0]  m_code;
  logic [6:0]  m_count;
  logic [5:0]  m_next, m_addr;
  logic [23:0] m_wdata;
  logic [25:0] m_enc;
  assign m_enc = ref_enc(in_op, in_rd, in_rs, in_imm);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_loading <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_hold <= 1'b1; m_done <= 1'b0; m_err <= 1'b0; m_code <= '0;
      m_count <= '0; m_next <= '0;
    end else begin
      m_we <= 1'b0;
      if (start) begin
        m_loading <= 1'b1; m_next <= '0; m_count <= '0;
        m_err <= 1'b0; m_code <= '0; m_done <= 1'b0; m_hold <= 1'b1;
      end else if (m_loading && in_valid) begin
        if (m_enc[25:24] != 2'd0 || m_count == 7'd64) begin
          m_loading <= 1'b0;
          m_err     <= 1'b1;
          m_code    <= (m_enc[25:24] != 2'd0) ? m_enc[25:24] : 2'd2;
        end else begin
          m_we    <= 1'b1;
          m_addr  <= m_next;
          m_wdata <= m_enc[23:0];
          m_next  <= m_next + 6'd1;
          m_count <= m_count + 7'd1;
          if (in_last) begin
            m_loading <= 1'b0; m_done <= 1'b1; m_hold <= 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus write capture
  int          wr_cnt = 0;
  logic [5:0]  cap_addr[$];
  int          cap_cyc[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle", {in_ready, pm_we, cpu_hold, done, err, err_code, count},
                     {m_loading, m_we, m_hold, m_done, m_err, m_code, m_count});
      if (m_we) check("write", {pm_addr, pm_wdata}, {m_addr, m_wdata});
    end
    if (pm_we === 1'b1) begin
      wr_cnt++;
      cap_addr.push_back(pm_addr);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic clear_caps();
    wr_cnt = 0; cap_addr.delete(); cap_cyc.delete();
  endtask

  // Present one tuple and hold it until accepted (bounded)
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [7:0] imm, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_imm = imm; in_last = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    tick();
  endtask

  localparam logic [43:0] RESET_VEC = {1'b0, 1'b0, 6'd0, 24'd0, 1'b1, 1'b0, 1'b0, 2'd0, 7'd0};

  function automatic logic [5:0] pick_op(input int r);
    case (r)
      0: return OP_NOP;      1: return OP_ADD;      2: return OP_ADDI;
      3: return OP_SUB;      4: return OP_SUBI;     5: return OP_MULL_INT;
      6: return OP_MULL_FLT; 7: return OP_LDI;      8: return OP_STR;
      9: return OP_J;        10: return OP_BEQ;     11: return OP_BNE;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs = '0; in_imm = '0;
    tick(); cmp_en = 1'b1; tick();
    check("reset_state", {in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, done, err, err_code, count}, RESET_VEC);
    reset = 1'b0;
    tick();

    // Model pins
    check("pin_addi", ref_enc(OP_ADDI, 5'd3, 5'd1, 8'h05), {2'd0, 24'h086105});
    check("pin_add",  ref_enc(OP_ADD, 5'd2, 5'd4, 8'hFF), {2'd0, 24'h044400});
    check("pin_j",    ref_enc(OP_J, 5'd7, 5'd5, 8'h3F),  {2'd0, 24'h24003F});
    check("pin_jbad", ref_enc(OP_J, 5'd0, 5'd0, 8'h40),  {2'd3, 24'h000000});
    check("pin_ill",  ref_enc(6'h3E, 5'd1, 5'd1, 8'h01), {2'd1, 24'h000000});

    // Single ADDI program
    pulse_start();
    send(OP_ADDI, 5'd3, 5'd1, 8'h05, 1'b1);
    check("addi_write", {pm_we, pm_addr, pm_wdata, done, cpu_hold}, {1'b1, 6'd0, 24'h086105, 1'b1, 1'b0});
    idle(); tick();

    // Field masking
    pulse_start();
    send(OP_ADD, 5'd2, 5'd4, 8'hFF, 1'b0);
    check("add_mask", pm_wdata, 24'h044400);
    send(OP_J, 5'd7, 5'd5, 8'h3F, 1'b1);
    check("j_mask", pm_wdata, 24'h24003F);
    idle(); tick();

    // Back-to-back stream
    pulse_start(); clear_caps();
    send(OP_LDI, 5'd1, 5'd0, 8'h11, 1'b0);
    send(OP_LDI, 5'd2, 5'd0, 8'h22, 1'b0);
    send(OP_LDI, 5'd3, 5'd0, 8'h33, 1'b1);
    idle(); tick();
    check("b2b_n", cap_addr.size(), 3);
    if (cap_addr.size() == 3) begin
      check("b2b_addr", {cap_addr[0], cap_addr[1], cap_addr[2]}, {6'd0, 6'd1, 6'd2});
      check("b2b_gap", cap_cyc[2] - cap_cyc[0], 2);
    end
    check("b2b_count", count, 7'd3);

    // Illegal opcode as second tuple
    pulse_start(); clear_caps();
    send(OP_ADDI, 5'd1, 5'd1, 8'h01, 1'b0);
    send(6'h3E, 5'd1, 5'd1, 8'h01, 1'b0);
    check("ill_flags", {err, err_code, cpu_hold, in_ready, pm_we}, {1'b1, 2'd1, 1'b1, 1'b0, 1'b0});
    idle(); tick(); tick();
    check("ill_writes", wr_cnt, 1);

    // Jump target one past the end
    pulse_start(); clear_caps();
    send(OP_J, 5'd0, 5'd0, 8'h40, 1'b1);
    idle(); tick(); tick();
    check("jrange", {err, err_code, done, cpu_hold}, {1'b1, 2'd3, 1'b0, 1'b1});
    check("jrange_writes", wr_cnt, 0);

    // Overflow on the 65th tuple
    pulse_start(); clear_caps();
    for (int i = 0; i < 64; i++) send(OP_ADD, 5'(i), 5'd1, 8'h00, 1'b0);
    send(OP_ADD, 5'd9, 5'd9, 8'h00, 1'b1);
    idle(); tick(); tick();
    check("ovf_writes", wr_cnt, 64);
    check("ovf_flags", {err, err_code, count, cpu_hold}, {1'b1, 2'd2, 7'd64, 1'b1});

    // start coincident with an accepted tuple
    pulse_start();
    send(OP_ADDI, 5'd1, 5'd2, 8'h03, 1'b0);
    send(OP_ADDI, 5'd1, 5'd2, 8'h04, 1'b0);
    start = 1'b1; in_valid = 1'b1; in_op = OP_ADDI; in_imm = 8'h77;
    tick();
    start = 1'b0; idle();
    check("start_wins", {pm_we, count, in_ready}, {1'b0, 7'd0, 1'b1});
    send(OP_SUBI, 5'd4, 5'd5, 8'h06, 1'b1);
    check("restart_addr", {pm_we, pm_addr, count}, {1'b1, 6'd0, 7'd1});
    idle(); tick();

    // reset mid-stream
    pulse_start();
    send(OP_ADDI, 5'd1, 5'd1, 8'h01, 1'b0);
    send(OP_ADDI, 5'd2, 5'd2, 8'h02, 1'b0);
    reset = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; idle();
    check("mid_reset", {in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, done, err, err_code, count}, RESET_VEC);
    tick();

    // Randomized stream checked by the per-cycle model comparison
    pulse_start();
    for (int n = 0; n < 4000; n++) begin
      int r;
      start    = ($urandom_range(0, 59) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      r        = $urandom_range(0, 13);
      in_op    = pick_op(r);
      in_rd    = 5'($urandom);
      in_rs    = 5'($urandom);
      in_imm   = (in_op == OP_J) ? 8'($urandom_range(0, 72)) : 8'($urandom);
      in_last  = ($urandom_range(0, 29) == 0);
      tick();
    end
    start = 1'b0; reset = 1'b0; idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
